// File: rtl/unary_stream_decoder.sv
// Popcounts LANES unary lanes over a WINDOW-cycle frame; result valid WINDOW+1 cycles after start, held until out_ready.
// Define UNARY_DEC_SATURATE_EN to clamp the accumulator at 2**OUT_W-1 on overflow (default build wraps).
module unary_stream_decoder #(
  parameter int LANES  = 16,
  parameter int WINDOW = 16,
  parameter int OUT_W  = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LANES-1:0] lanes,
  output logic             busy,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  localparam int PC_W  = $clog2(LANES + 1);
  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int SUM_W = OUT_W + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [OUT_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] sum;
  logic             sum_ovf;
  logic             last;
  logic             sample;
  logic             restart;

  always_comb begin
    pc = '0;
    for (int i = 0; i < LANES; i++) begin
      pc = pc + PC_W'(lanes[i]);
    end
  end

  // One extra bit on the adder exposes the carry used as the overflow flag.
  assign sum     = {1'b0, acc} + SUM_W'(pc);
  assign sum_ovf = sum[OUT_W];
  assign last    = (cnt == CNT_W'(WINDOW - 1));

`ifdef UNARY_DEC_SATURATE_EN
  assign acc_nxt = sum_ovf ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
`else
  assign acc_nxt = sum[OUT_W-1:0];
`endif

  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    restart   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
          restart   = 1'b1;
        end
      end
      ACCUM: begin
        // A start mid-frame discards the partial frame; that cycle's lanes are not sampled.
        if (start) begin
          restart = 1'b1;
        end else begin
          sample = 1'b1;
          if (last) state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (start) begin
            state_nxt = ACCUM;
            restart   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out       <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt == ACCUM);
      out_valid <= (state_nxt == DONE);
      if (restart) begin
        acc      <= '0;
        cnt      <= '0;
        overflow <= 1'b0;
      end else if (sample) begin
        acc      <= acc_nxt;
        cnt      <= cnt + CNT_W'(1);
        overflow <= overflow | sum_ovf;
        if (last) out <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Scoreboarded bench: a 9-bit and an 8-bit result instance share stimulus; directed frames with hand-computed totals.
module tb_unary_stream_decoder;

`ifdef UNARY_DEC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] lanes = '0;
  logic        out_ready = 1'b1;
  logic        busy, out_valid, overflow;
  logic [8:0]  out;
  logic        busy8, out_valid8, overflow8;
  logic [7:0]  out8;

  typedef struct {
    logic [8:0] o;
    logic       v;
  } exp_t;

  exp_t q9[$];
  exp_t q8[$];
  exp_t e9, e8;
  logic [15:0] pat[16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unary_stream_decoder #(.LANES(16), .WINDOW(16), .OUT_W(9)) dut (
    .clk(clk), .reset(reset), .start(start), .lanes(lanes), .busy(busy),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
  );

  unary_stream_decoder #(.LANES(16), .WINDOW(16), .OUT_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .lanes(lanes), .busy(busy8),
    .out(out8), .out_valid(out_valid8), .out_ready(out_ready), .overflow(overflow8)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, got, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues start, drives pat[] for 16 samples, returns in the cycle out_valid should rise.
  task automatic frame(input int total);
    exp_t x;
    x.o = total[8:0];
    x.v = (total > 511);
    q9.push_back(x);
    x.v = (total > 255);
    x.o = {1'b0, (x.v && SAT) ? 8'hFF : total[7:0]};
    q8.push_back(x);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      lanes = pat[i];
      chk("busy_during_frame", 32'(busy), 1);
      step();
    end
    lanes = '0;
    chk("busy_after_frame", 32'(busy), 0);
    chk("valid_after_frame", 32'(out_valid), 1);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q9.size() == 0) begin
        chk("unexpected_result9", 32'(out), 32'h1FF);
      end else begin
        e9 = q9.pop_front();
        chk("out9", 32'(out), 32'(e9.o));
        chk("overflow9", 32'(overflow), 32'(e9.v));
      end
    end
    if (!reset && out_valid8 && out_ready) begin
      if (q8.size() == 0) begin
        chk("unexpected_result8", 32'(out8), 32'h1FF);
      end else begin
        e8 = q8.pop_front();
        chk("out8", 32'(out8), 32'(e8.o));
        chk("overflow8", 32'(overflow8), 32'(e8.v));
      end
    end
  end

  initial begin
    repeat (3) step();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_out", 32'(out), 0);
    chk("reset_overflow", 32'(overflow), 0);
    chk("reset_valid8", 32'(out_valid8), 0);
    reset = 1'b0;
    step();

    // 1: three all-ones samples -> 48
    for (int i = 0; i < 16; i++) pat[i] = (i < 3) ? 16'hFFFF : 16'h0000;
    frame(48);
    step();
    chk("idle_after_accept", 32'(out_valid), 0);

    // 2: a=5,b=3 on lanes 0..2 for 5 cycles, c=7 on lane 15 -> 15+7 = 22; hold with ready low
    for (int i = 0; i < 16; i++) pat[i] = (i < 5) ? 16'h8007 : (i < 7) ? 16'h8000 : 16'h0000;
    out_ready = 1'b0;
    frame(22);
    for (int k = 0; k < 5; k++) begin
      start = k[0];
      step();
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_out", 32'(out), 22);
      chk("hold_not_busy", 32'(busy), 0);
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    chk("drop_valid", 32'(out_valid), 0);
    chk("keep_out", 32'(out), 22);
    step();

    // 3: sixteen all-ones samples -> 256 (fits 9 bits, overflows 8 bits)
    for (int i = 0; i < 16; i++) pat[i] = 16'hFFFF;
    frame(256);
    step();

    // 4: aborted frame after 4 all-ones samples, then 16 x 0001 -> 16
    start = 1'b1;
    step();
    start = 1'b0;
    lanes = 16'hFFFF;
    repeat (4) step();
    for (int i = 0; i < 16; i++) pat[i] = 16'h0001;
    frame(16);
    step();

    // 5: reset during sample 8, then a fresh frame of 00FF -> 128
    start = 1'b1;
    step();
    start = 1'b0;
    lanes = 16'hFFFF;
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    lanes = '0;
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_valid", 32'(out_valid), 0);
    chk("midreset_out", 32'(out), 0);
    chk("midreset_overflow", 32'(overflow), 0);
    step();
    for (int i = 0; i < 16; i++) pat[i] = 16'h00FF;
    frame(128);
    step();

    // 6: back-to-back, second start on the accept cycle; first sample of frame 2 is all-ones
    for (int i = 0; i < 16; i++) pat[i] = 16'h0003;
    frame(32);
    for (int i = 0; i < 16; i++) pat[i] = (i == 0) ? 16'hFFFF : 16'h0001;
    frame(31);
    step();

    for (int k = 0; k < 50 && (q9.size() != 0 || q8.size() != 0); k++) step();
    chk("drain9", 32'(q9.size()), 0);
    chk("drain8", 32'(q8.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
